seg_led_mux: RTL and testbench
==============================

SEG_LED_MUX -- requirements
Module: seg_led_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter CLK_DIV, default 125000, clocks per digit scan slot (legal >= 1).
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 0; 1 inverts all segment outputs.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port load_valid  input  1  new display value offered.
REQ-007 SHALL have port load_value  input  4*NUM_DIGITS  hex nibbles, nibble 0 = least significant digit.
REQ-008 SHALL have port load_ready  output  1  block can accept a value.
REQ-009 SHALL have port lz_blank  input  1  enable leading-zero blanking.
REQ-010 SHALL have port digit_select  output  NUM_DIGITS  one-hot digit enable, active-high.
REQ-011 SHALL have port seg_led  output  7  segments, bit0=a .. bit6=g.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse per completed scan frame.

Function
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 and assert internal tick in the cycle count = CLK_DIV-1, then wrap to 0; CLK_DIV=1 ticks every cycle.
REQ-014 Digit index SHALL advance by 1 on tick, wrapping NUM_DIGITS-1 -> 0; that wrap cycle is the frame boundary.
REQ-015 frame_done SHALL be high exactly one cycle, registered, the cycle after the frame boundary.
REQ-016 digit_select and seg_led SHALL be registered, reflecting index and display register with 1-cycle latency.
REQ-017 Handshake: transfer when load_valid && load_ready; value stored in pending register; load_ready low from next cycle.
REQ-018 At a frame boundary with pending full, pending SHALL copy to display register and load_ready SHALL rise next cycle; display never changes mid-frame.
REQ-019 Transfer in the frame-boundary cycle with pending empty SHALL commit at the following boundary, not the current one.
REQ-020 Decode SHALL be hex: 0-F -> 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-021 With lz_blank=1, a digit SHALL be blank (all segments off) when its nibble and all more-significant nibbles are 0; digit 0 is never blanked.
REQ-022 SEG_ACTIVE_LOW=1 SHALL invert seg_led (blank = 7F); digit_select polarity unchanged.

Reset
REQ-023 While rst high: prescaler 0, index 0, display and pending registers 0, pending empty, load_ready 1, frame_done 0, digit_select 0, seg_led blank.
REQ-024 Reset mid-frame or mid-handshake SHALL discard pending value; first cycle after release shows digit 0 = "0" (3F).

Configuration
REQ-025 Macro SEG_LED_MUX_DP_EN defined SHALL add input load_dp (NUM_DIGITS, latched/committed with load_value) and output seg_dp (1, registered, same latency and polarity as seg_led; blanked digits have dp off).
REQ-026 Without SEG_LED_MUX_DP_EN these ports and their registers SHALL not exist; all other behaviour identical.

Structure
REQ-027 Package seg_led_pkg SHALL hold the hex segment table constant, SEG_BLANK constant and nibble-width constant.
REQ-028 Combinational decoder SHALL be sub-module seg_hex_decode (nibble, blank -> 7-bit active-high segments); polarity applied in seg_led_mux.

Verification
REQ-029 NUM_DIGITS=4, CLK_DIV=3, reset release -> digit_select 0001,0010,0100,1000 each held 3 cycles, frame_done pulse every 12 cycles.
REQ-030 Load 16'h12AF mid-frame -> load_ready low, display unchanged until boundary; next frame shows 71,77,5B,06 on digits 0..3; load_ready high after commit.
REQ-031 lz_blank=1, value 16'h0050 -> digits 3,2 blank (00), digit 1 = 6D, digit 0 = 3F; value 0 -> only digit 0 lit, 3F.
REQ-032 Transfer exactly on boundary cycle with pending empty -> commit one frame later; second load_valid while load_ready low ignored.
REQ-033 SEG_ACTIVE_LOW=1, value nibble 8 -> seg_led 00; blank -> 7F; rst asserted mid-frame with pending full -> pending lost, outputs match REQ-023.
REQ-034 With SEG_LED_MUX_DP_EN, load_dp=4'b0010 -> seg_dp active only while digit_select=0010.

Source files
------------

// File: rtl/seg_led_pkg.sv
// Shared constants for the multiplexed seven-segment display block.
// Segment order is bit0 = a .. bit6 = g, active-high.
package seg_led_pkg;

  localparam int NIB_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Hex glyph table, entry n = glyph for nibble value n (entry 15 listed first).
  localparam logic [15:0][6:0] SEG_HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder with blanking; output is active-high,
// polarity is applied by the caller.
module seg_hex_decode
  import seg_led_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  input  logic             i_blank,
  output logic [6:0]       o_seg
);

  always_comb begin
    o_seg = i_blank ? SEG_BLANK : SEG_HEX_TABLE[i_nibble];
  end

endmodule

// File: rtl/seg_led_mux.sv
// Time-multiplexed hex display driver with frame-synchronous value updates.
// Optional decimal points are enabled by defining SEG_LED_MUX_DP_EN.
module seg_led_mux
  import seg_led_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int CLK_DIV        = 125000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  input  logic [NIB_W*NUM_DIGITS-1:0] load_value,
  output logic                        load_ready,
  input  logic                        lz_blank,
  output logic [NUM_DIGITS-1:0]       digit_select,
  output logic [6:0]                  seg_led,
  output logic                        frame_done
`ifdef SEG_LED_MUX_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]       load_dp,
  output logic                        seg_dp
`endif
);

  localparam int VAL_W = NIB_W * NUM_DIGITS;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_POL  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [DIV_W-1:0]      r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [VAL_W-1:0]      r_disp;
  logic [VAL_W-1:0]      r_pend;
  logic                  r_pend_full;
  logic                  r_frame_done;
  logic [NUM_DIGITS-1:0] r_dsel;
  logic [6:0]            r_seg;

  logic                  w_tick;
  logic                  w_boundary;
  logic                  w_xfer;
  logic                  w_commit;
  logic [NUM_DIGITS-1:0] w_blank_mask;
  logic [NIB_W-1:0]      w_cur_nib;
  logic                  w_cur_blank;
  logic [NUM_DIGITS-1:0] w_cur_dsel;
  logic [6:0]            w_seg_raw;

`ifdef SEG_LED_MUX_DP_EN
  localparam logic DP_POL = SEG_ACTIVE_LOW;

  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic                  r_seg_dp;
  logic                  w_cur_dp;
`endif

  assign w_tick     = (r_presc == DIV_LAST);
  assign w_boundary = w_tick && (r_idx == IDX_LAST);
  // Pending and display never both change in one cycle: a transfer needs
  // pending empty, a commit needs it full.
  assign w_xfer     = load_valid && !r_pend_full;
  assign w_commit   = w_boundary && r_pend_full;

  // A digit is blank when it and every more-significant nibble are zero.
  always_comb begin
    logic w_upper_zero;
    w_upper_zero = 1'b1;
    w_blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_upper_zero    = w_upper_zero && (r_disp[NIB_W*i +: NIB_W] == '0);
      w_blank_mask[i] = lz_blank && w_upper_zero && (i != 0);
    end
  end

  always_comb begin
    w_cur_nib   = '0;
    w_cur_blank = 1'b0;
    w_cur_dsel  = '0;
`ifdef SEG_LED_MUX_DP_EN
    w_cur_dp    = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_nib     = r_disp[NIB_W*i +: NIB_W];
        w_cur_blank   = w_blank_mask[i];
        w_cur_dsel[i] = 1'b1;
`ifdef SEG_LED_MUX_DP_EN
        w_cur_dp      = r_disp_dp[i] && !w_blank_mask[i];
`endif
      end
    end
  end

  seg_hex_decode u_dec (
    .i_nibble (w_cur_nib),
    .i_blank  (w_cur_blank),
    .o_seg    (w_seg_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_full  <= 1'b0;
      r_frame_done <= 1'b0;
      r_dsel       <= '0;
      r_seg        <= SEG_BLANK ^ SEG_POL;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
      r_frame_done <= w_boundary;

      if (w_xfer) begin
        r_pend      <= load_value;
        r_pend_full <= 1'b1;
      end else if (w_commit) begin
        r_disp      <= r_pend;
        r_pend_full <= 1'b0;
      end

      // Output stage: one cycle behind the scan index and display register.
      r_dsel <= w_cur_dsel;
      r_seg  <= w_seg_raw ^ SEG_POL;
    end
  end

`ifdef SEG_LED_MUX_DP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_dp <= '0;
      r_disp_dp <= '0;
      r_seg_dp  <= DP_POL;
    end else begin
      if (w_xfer) begin
        r_pend_dp <= load_dp;
      end else if (w_commit) begin
        r_disp_dp <= r_pend_dp;
      end
      r_seg_dp <= w_cur_dp ^ DP_POL;
    end
  end

  assign seg_dp = r_seg_dp;
`endif

  assign load_ready   = !r_pend_full;
  assign digit_select = r_dsel;
  assign seg_led      = r_seg;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_seg_led_mux.sv
// Scoreboard bench for seg_led_mux: 4 digits, 3 clocks per slot, with an
// active-high and an active-low instance driven from the same stimulus.
module tb_seg_led_mux;

  localparam int ND = 4;
  localparam int CD = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] load_value = '0;
  logic        load_ready, load_ready_n;
  logic        frame_done, frame_done_n;
  logic [3:0]  digit_select, digit_select_n;
  logic [6:0]  seg_led, seg_led_n;
`ifdef SEG_LED_MUX_DP_EN
  logic [3:0]  load_dp = '0;
  logic        seg_dp, seg_dp_n;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] dsel;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  seg_led_mux #(.NUM_DIGITS(ND), .CLK_DIV(CD), .SEG_ACTIVE_LOW(1'b0)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_value   (load_value),
    .load_ready   (load_ready),
    .lz_blank     (lz_blank),
    .digit_select (digit_select),
    .seg_led      (seg_led),
    .frame_done   (frame_done)
`ifdef SEG_LED_MUX_DP_EN
    ,
    .load_dp      (load_dp),
    .seg_dp       (seg_dp)
`endif
  );

  seg_led_mux #(.NUM_DIGITS(ND), .CLK_DIV(CD), .SEG_ACTIVE_LOW(1'b1)) u_dut_n (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_value   (load_value),
    .load_ready   (load_ready_n),
    .lz_blank     (lz_blank),
    .digit_select (digit_select_n),
    .seg_led      (seg_led_n),
    .frame_done   (frame_done_n)
`ifdef SEG_LED_MUX_DP_EN
    ,
    .load_dp      (load_dp),
    .seg_dp       (seg_dp_n)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic lz, input logic [3:0] dp);
    for (int d = 0; d < ND; d++) begin
      exp_t e;
      logic blank;
      blank  = lz && (d != 0) && ((v >> (4 * d)) == 16'h0);
      e.dsel = 4'b0001 << d;
      e.seg  = blank ? 7'h00 : hex7(v[4*d +: 4]);
      e.dp   = dp[d] && !blank;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 40);
    check("fd_wait", frame_done, 1);
  endtask

  // Starts in a frame_done cycle, checks one 12-cycle frame, ends in the next.
  // ld_at >= 0 offers value v at that slot, then a junk value while not ready.
  task automatic scan_frame(input int ld_at, input logic [15:0] v, input logic [3:0] dpv);
    exp_t       e;
    logic [6:0] seg_n_exp;
    e = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 3 == 0) begin
        if (exp_q.size() == 0) check("q_empty", 1, 0);
        else e = exp_q.pop_front();
      end
      seg_n_exp = ~e.seg;
      check("dsel", digit_select, e.dsel);
      check("seg", seg_led, e.seg);
      check("dsel_n", digit_select_n, e.dsel);
      check("seg_n", seg_led_n, seg_n_exp);
      check("fd", frame_done, (c == 11));
`ifdef SEG_LED_MUX_DP_EN
      check("dp", seg_dp, e.dp);
      check("dp_n", seg_dp_n, !e.dp);
`endif
      if (c == ld_at) begin
        load_valid = 1'b1;
        load_value = v;
`ifdef SEG_LED_MUX_DP_EN
        load_dp    = dpv;
`endif
      end else if (ld_at >= 0 && c == ld_at + 1) begin
        check("rdy_low", load_ready, 0);
        load_value = 16'hFFFF;
`ifdef SEG_LED_MUX_DP_EN
        load_dp    = 4'hF;
`endif
      end else if (ld_at >= 0 && c == ld_at + 3) begin
        load_valid = 1'b0;
      end
      if (c == 11 && ld_at >= 0 && ld_at < 10) check("rdy_commit", load_ready, 1);
    end
    load_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dsel", digit_select, 0);
    check("rst_seg", seg_led, 7'h00);
    check("rst_seg_n", seg_led_n, 7'h7F);
    check("rst_fd", frame_done, 0);
    check("rst_rdy", load_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    check("rel_dsel", digit_select, 4'b0001);
    check("rel_seg", seg_led, 7'h3F);
    check("rel_seg_n", seg_led_n, 7'h40);

    wait_fd();
    push_frame(16'h0000, 1'b0, 4'b0000);
    scan_frame(-1, 16'h0, 4'h0);
    push_frame(16'h0000, 1'b0, 4'b0000);
    scan_frame(4, 16'h12AF, 4'b0010);
    push_frame(16'h12AF, 1'b0, 4'b0010);
    scan_frame(-1, 16'h0, 4'h0);

    lz_blank = 1'b1;
    push_frame(16'h12AF, 1'b1, 4'b0010);
    scan_frame(2, 16'h0050, 4'b1110);
    push_frame(16'h0050, 1'b1, 4'b1110);
    scan_frame(10, 16'h0000, 4'b0000);
    push_frame(16'h0050, 1'b1, 4'b1110);
    scan_frame(-1, 16'h0, 4'h0);
    push_frame(16'h0000, 1'b1, 4'b0000);
    scan_frame(5, 16'h8888, 4'b0101);
    lz_blank = 1'b0;
    push_frame(16'h8888, 1'b0, 4'b0101);
    scan_frame(-1, 16'h0, 4'h0);

    // Reset mid-frame with a value pending.
    repeat (3) @(negedge clk);
    load_valid = 1'b1;
    load_value = 16'h4321;
`ifdef SEG_LED_MUX_DP_EN
    load_dp    = 4'b1111;
`endif
    @(negedge clk);
    check("mid_rdy_low", load_ready, 0);
    load_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_dsel", digit_select, 0);
    check("mrst_seg", seg_led, 7'h00);
    check("mrst_seg_n", seg_led_n, 7'h7F);
    check("mrst_fd", frame_done, 0);
    check("mrst_rdy", load_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    check("mrel_dsel", digit_select, 4'b0001);
    check("mrel_seg", seg_led, 7'h3F);
    check("mrel_rdy", load_ready, 1);
    wait_fd();
    push_frame(16'h0000, 1'b0, 4'b0000);
    scan_frame(-1, 16'h0, 4'h0);

    check("q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
